// File: rtl/mgmt_gpio_in_sync.sv
// Synchronizes and debounces the management GPIO inputs and raises sticky edge flags.
// Define MGMT_GPIO_DB_BYPASS_EN to drop the prescaler and debounce filter.
module mgmt_gpio_in_sync #(
  parameter int WIDTH       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 16,
  parameter int DB_CNT      = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_in_sync,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] pend_clr,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < SYNC_STAGES; n++) sync_q[n] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int n = 1; n < SYNC_STAGES; n++) sync_q[n] <= sync_q[n-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef MGMT_GPIO_DB_BYPASS_EN

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) gpio_in_sync <= '0;
    else          gpio_in_sync <= s;
  end

  assign update = s ^ gpio_in_sync;

`else

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [PW-1:0] PS_MAX  = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [CW-1:0] db_cnt [WIDTH];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)               pre_cnt <= '0;
    else if (pre_cnt == PS_MAX) pre_cnt <= '0;
    else                        pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == PS_MAX);

  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++)
      update[i] = tick && (s[i] != gpio_in_sync[i]) && (db_cnt[i] == CNT_MAX);
  end

  // A bit flips only after DB_CNT consecutive mismatching ticks; any agreeing tick restarts the run.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gpio_in_sync <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] != gpio_in_sync[i]) begin
          if (db_cnt[i] == CNT_MAX) begin
            gpio_in_sync[i] <= s[i];
            db_cnt[i]       <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

`endif

  assign rise = update & s;
  assign fall = update & ~s;

  // A new edge event beats a simultaneous clear so no event is ever lost.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) pending <= '0;
    else          pending <= (pending & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
  end

  assign irq = |pending;

endmodule

// File: tb/tb_mgmt_gpio_in_sync.sv
// Self-checking bench: a fast-tick instance (PRESCALE=1) and a default instance share stimulus
// and are compared every cycle against a run-length reference model plus directed checkpoints.
module tb_mgmt_gpio_in_sync;

  localparam int W  = 18;
  localparam int SS = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gin, ren, fen, pclr;
  logic [W-1:0] sync_f, pend_f, sync_s, pend_s;
  logic         irq_f, irq_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mgmt_gpio_in_sync #(.WIDTH(W), .SYNC_STAGES(SS), .PRESCALE(1), .DB_CNT(DB)) dut_fast (
    .wb_clk_i(clk), .wb_rst_i(rst), .gpio_in(gin), .gpio_in_sync(sync_f),
    .rise_en(ren), .fall_en(fen), .pend_clr(pclr), .pending(pend_f), .irq(irq_f));

  mgmt_gpio_in_sync dut_slow (
    .wb_clk_i(clk), .wb_rst_i(rst), .gpio_in(gin), .gpio_in_sync(sync_s),
    .rise_en(ren), .fall_en(fen), .pend_clr(pclr), .pending(pend_s), .irq(irq_s));

  // Reference model: index 0 ticks every clock, index 1 every 16th clock since reset.
  // A level is accepted once it has disagreed with the output on DB consecutive ticks.
  logic [W-1:0] m_hist [SS];
  logic [W-1:0] m_out  [2];
  logic [W-1:0] m_pend [2];
  int           m_run  [2][W];
  int           m_cyc;

  always @(posedge clk) begin : ref_model
    logic [W-1:0] s, upd;
    int per;
    if (rst) begin
      for (int n = 0; n < SS; n++) m_hist[n] = '0;
      for (int j = 0; j < 2; j++) begin
        m_out[j]  = '0;
        m_pend[j] = '0;
        for (int i = 0; i < W; i++) m_run[j][i] = 0;
      end
      m_cyc = 0;
    end else begin
      s = m_hist[SS-1];
      for (int j = 0; j < 2; j++) begin
        per = (j == 0) ? 1 : 16;
        upd = '0;
`ifdef MGMT_GPIO_DB_BYPASS_EN
        upd = s ^ m_out[j];
`else
        if ((m_cyc % per) == per - 1) begin
          for (int i = 0; i < W; i++) begin
            if (s[i] != m_out[j][i]) begin
              m_run[j][i]++;
              if (m_run[j][i] == DB) begin
                upd[i] = 1'b1;
                m_run[j][i] = 0;
              end
            end else begin
              m_run[j][i] = 0;
            end
          end
        end
`endif
        m_pend[j] = (m_pend[j] & ~pclr) | (upd & s & ren) | (upd & ~s & fen);
        m_out[j]  = m_out[j] ^ upd;
      end
      for (int n = SS - 1; n > 0; n--) m_hist[n] = m_hist[n-1];
      m_hist[0] = gin;
      m_cyc++;
    end
  end

  task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("fast_sync", sync_f, m_out[0]);
    checkValue("fast_pend", pend_f, m_pend[0]);
    checkValue("fast_irq",  W'(irq_f), W'(|m_pend[0]));
    checkValue("slow_sync", sync_s, m_out[1]);
    checkValue("slow_pend", pend_s, m_pend[1]);
    checkValue("slow_irq",  W'(irq_s), W'(|m_pend[1]));
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    logic [W-1:0] seen;
    rst = 1'b1; gin = '0; ren = '0; fen = '0; pclr = '0;
    applyStimulus(2);
    checkValue("reset_sync", sync_f | sync_s, '0);
    checkValue("reset_pend", pend_f | pend_s, '0);
    rst = 1'b0;
    applyStimulus(3);

`ifndef MGMT_GPIO_DB_BYPASS_EN
    // Step on bit 3: accepted five edges after capture, pending raised on the same edge.
    gin[3] = 1'b1; ren[3] = 1'b1;
    applyStimulus(5);
    checkValue("step3_early", sync_f, '0);
    applyStimulus(1);
    checkValue("step3_sync", sync_f, 18'h00008);
    checkValue("step3_pend", pend_f, 18'h00008);
    checkValue("step3_irq",  W'(irq_f), W'(1));

    // Reset in the middle of a debounce run on bit 2 throws the partial count away.
    gin[2] = 1'b1;
    applyStimulus(4);
    rst = 1'b1;
    applyStimulus(1);
    checkValue("midrst_sync", sync_f | sync_s, '0);
    checkValue("midrst_pend", pend_f | pend_s, '0);
    checkValue("midrst_irq",  W'(irq_f | irq_s), '0);
    rst = 1'b0;
    applyStimulus(5);
    checkValue("midrst_b2_early", W'(sync_f[2]), '0);
    applyStimulus(1);
    checkValue("midrst_b2_late", W'(sync_f[2]), W'(1));

    // Bit 5 with only the falling enable: the rise must not flag, the fall must.
    pclr = '1;
    applyStimulus(1);
    pclr = '0;
    fen[5] = 1'b1;
    gin[5] = 1'b1;
    applyStimulus(6);
    checkValue("b5_rise_sync", W'(sync_f[5]), W'(1));
    checkValue("b5_rise_pend", W'(pend_f[5]), '0);
    gin[5] = 1'b0;
    applyStimulus(6);
    checkValue("b5_fall_sync", W'(sync_f[5]), '0);
    checkValue("b5_fall_pend", W'(pend_f[5]), W'(1));

    // Bit 7: clear alone empties pending; a fall coinciding with the clear keeps it set.
    ren[7] = 1'b1; fen[7] = 1'b1; gin[7] = 1'b1;
    applyStimulus(6);
    checkValue("b7_set", W'(pend_f[7]), W'(1));
    pclr = '1;
    applyStimulus(1);
    pclr = '0;
    checkValue("b7_clr_pend", pend_f, '0);
    checkValue("b7_clr_irq",  W'(irq_f), '0);
    gin[7] = 1'b0;
    applyStimulus(5);
    checkValue("b7_prefall", W'(pend_f[7]), '0);
    pclr[7] = 1'b1;
    applyStimulus(1);
    pclr = '0;
    checkValue("b7_set_wins", W'(pend_f[7]), W'(1));

    // Default instance: a 40-clock pulse on bit 0 spans at most three ticks and is rejected.
    pclr = '1;
    applyStimulus(1);
    pclr = '0;
    ren[0] = 1'b1;
    seen = '0;
    gin[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1);
      seen = seen | W'(sync_s[0]) | W'(pend_s[0]);
    end
    gin[0] = 1'b0;
    for (int c = 0; c < 80; c++) begin
      applyStimulus(1);
      seen = seen | W'(sync_s[0]) | W'(pend_s[0]);
    end
    checkValue("glitch_reject", seen, '0);
    gin[0] = 1'b1;
    applyStimulus(100);
    checkValue("hold_accept", W'(sync_s[0]), W'(1));
`else
    // Bypass: bit 17 follows the synchronizer output two edges after capture.
    ren[17] = 1'b1;
    gin[17] = 1'b1;
    applyStimulus(2);
    checkValue("byp17_early", W'(sync_f[17]), '0);
    applyStimulus(1);
    checkValue("byp17_sync", W'(sync_f[17]), W'(1));
    checkValue("byp17_pend", W'(pend_f[17]), W'(1));
`endif

    // Random traffic with quiet windows so the slow filter also gets to accept levels.
    for (int c = 0; c < 800; c++) begin
      if ((c % 50) == 0) begin
        ren = W'($urandom);
        fen = W'($urandom);
      end
      if ((c % 100) < 70)
        gin = gin ^ (W'($urandom) & W'($urandom) & W'($urandom) & W'($urandom));
      pclr = W'($urandom) & W'($urandom) & W'($urandom);
      rst  = (c == 400);
      applyStimulus(1);
    end
    rst = 1'b0;
    pclr = '0;
    applyStimulus(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
